nios2_dbg_sysclk_cmd_decoder: RTL and testbench

//  Consumes the debug slave TCK-side outputs: shift register sr, ir_in and the update strobes
//  vs_udr/vs_uir, all asynchronous to clk. Synchronises the strobes into the CPU clock domain
//  and captures sr into jdo. Decodes ir/jdo into one-cycle take_action_* / take_no_action_*

---
 rtl/nios2_dbg_pkg.sv | 29 ++
 rtl/dbg_sync_edge.sv | 27 ++
 rtl/nios2_dbg_sysclk_cmd_decoder.sv | 117 +++++++++++
 tb/tb_nios2_dbg_sysclk_cmd_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared debug-slave definitions: instruction-register codes, jdo bit positions
// and the bundle of decoded take_* pulses.
package nios2_dbg_pkg;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_RSVD      = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  localparam int JDO_B15 = 15;
  localparam int JDO_B34 = 34;
  localparam int JDO_B35 = 35;
  localparam int JDO_B36 = 36;
  localparam int JDO_B37 = 37;

  typedef struct packed {
    logic ocimem_a;
    logic no_ocimem_a;
    logic ocimem_b;
    logic break_a;
    logic no_break_a;
    logic break_b;
    logic no_break_b;
    logic break_c;
    logic no_break_c;
    logic tracectrl;
  } take_t;

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level followed by a rising-edge
// detector producing a single-cycle strobe in the clk domain.
module dbg_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic strobe
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], level};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign strobe = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/nios2_dbg_sysclk_cmd_decoder.sv
// Brings TCK-side update strobes into the CPU clock domain, captures the shift
// register into jdo and decodes ir/jdo into one-cycle take_* pulses.
module nios2_dbg_sysclk_cmd_decoder
  import nios2_dbg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SR_W        = 38,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SR_W-1:0]  sr,
  input  logic [1:0]       ir_in,
  input  logic             vs_udr,
  input  logic             vs_uir,
  output logic [SR_W-1:0]  jdo,
  output logic             take_action_ocimem_a,
  output logic             take_no_action_ocimem_a,
  output logic             take_action_ocimem_b,
  output logic             take_action_break_a,
  output logic             take_no_action_break_a,
  output logic             take_action_break_b,
  output logic             take_no_action_break_b,
  output logic             take_action_break_c,
  output logic             take_no_action_break_c,
  output logic             take_action_tracectrl,
  output logic [CNT_W-1:0] cmd_count
);

  logic       udr_stb_p0;
  logic       uir_stb_p0;
  logic [1:0] ir_q;
  logic       act_pend;
  take_t      take_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Exactly one field (or none) is set, so the registered outputs are one-hot-or-zero.
  function automatic take_t decode(input logic [1:0] ir, input logic [SR_W-1:0] w);
    take_t t;
    t = '0;
    case (ir)
      IR_OCIMEM: begin
        if (w[JDO_B35])      t.ocimem_b    = 1'b1;
        else if (w[JDO_B34]) t.ocimem_a    = 1'b1;
        else                 t.no_ocimem_a = 1'b1;
      end
      IR_BREAK: begin
        if (!w[JDO_B36]) begin
          if (w[JDO_B37]) t.break_a    = 1'b1;
          else            t.no_break_a = 1'b1;
        end else if (!w[JDO_B35]) begin
          if (w[JDO_B37]) t.break_b    = 1'b1;
          else            t.no_break_b = 1'b1;
        end else begin
          if (w[JDO_B37]) t.break_c    = 1'b1;
          else            t.no_break_c = 1'b1;
        end
      end
      IR_TRACECTRL: t.tracectrl = w[JDO_B15];
      default:      t = '0;
    endcase
    return t;
  endfunction

  dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk    (clk),
    .reset  (reset),
    .level  (vs_udr),
    .strobe (udr_stb_p0)
  );

  dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk    (clk),
    .reset  (reset),
    .level  (vs_uir),
    .strobe (uir_stb_p0)
  );

  // p1: capture TCK-side data on the synchronised strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo      <= '0;
      ir_q     <= '0;
      act_pend <= 1'b0;
    end else begin
      if (uir_stb_p0) ir_q <= ir_in;
      if (udr_stb_p0) jdo  <= sr;
      act_pend <= udr_stb_p0;
    end
  end

  // p2: registered decode and command counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      take_p2   <= '0;
      cmd_count <= '0;
    end else begin
      take_p2 <= act_pend ? decode(ir_q, jdo) : '0;
      if (act_pend) cmd_count <= sat_inc(cmd_count);
    end
  end

  assign take_action_ocimem_a    = take_p2.ocimem_a;
  assign take_no_action_ocimem_a = take_p2.no_ocimem_a;
  assign take_action_ocimem_b    = take_p2.ocimem_b;
  assign take_action_break_a     = take_p2.break_a;
  assign take_no_action_break_a  = take_p2.no_break_a;
  assign take_action_break_b     = take_p2.break_b;
  assign take_no_action_break_b  = take_p2.no_break_b;
  assign take_action_break_c     = take_p2.break_c;
  assign take_no_action_break_c  = take_p2.no_break_c;
  assign take_action_tracectrl   = take_p2.tracectrl;

endmodule

// File: tb/tb_nios2_dbg_sysclk_cmd_decoder.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor checks them.
module tb_nios2_dbg_sysclk_cmd_decoder;

  localparam int SR_W  = 38;
  localparam int CNT_W = 8;

  // bit order of take_vec: {oa, noa, ob, ba, nba, bb, nbb, bc, nbc, tr}
  localparam logic [9:0] T_OA  = 10'b1000000000;
  localparam logic [9:0] T_NOA = 10'b0100000000;
  localparam logic [9:0] T_OB  = 10'b0010000000;
  localparam logic [9:0] T_BA  = 10'b0001000000;
  localparam logic [9:0] T_NBA = 10'b0000100000;
  localparam logic [9:0] T_BB  = 10'b0000010000;
  localparam logic [9:0] T_NBB = 10'b0000001000;
  localparam logic [9:0] T_BC  = 10'b0000000100;
  localparam logic [9:0] T_NBC = 10'b0000000010;
  localparam logic [9:0] T_TR  = 10'b0000000001;
  localparam logic [9:0] T_NONE = 10'b0000000000;
  localparam logic [SR_W-1:0] BASE = 38'h2A5C3C96E1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [SR_W-1:0]  sr = '0;
  logic [1:0]       ir_in = 2'b00;
  logic             vs_udr = 1'b0;
  logic             vs_uir = 1'b0;
  logic [SR_W-1:0]  jdo;
  logic             t_oa, t_noa, t_ob, t_ba, t_nba, t_bb, t_nbb, t_bc, t_nbc, t_tr;
  logic [CNT_W-1:0] cmd_count;

  nios2_dbg_sysclk_cmd_decoder #(.SYNC_STAGES(2), .SR_W(SR_W), .CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .sr                      (sr),
    .ir_in                   (ir_in),
    .vs_udr                  (vs_udr),
    .vs_uir                  (vs_uir),
    .jdo                     (jdo),
    .take_action_ocimem_a    (t_oa),
    .take_no_action_ocimem_a (t_noa),
    .take_action_ocimem_b    (t_ob),
    .take_action_break_a     (t_ba),
    .take_no_action_break_a  (t_nba),
    .take_action_break_b     (t_bb),
    .take_no_action_break_b  (t_nbb),
    .take_action_break_c     (t_bc),
    .take_no_action_break_c  (t_nbc),
    .take_action_tracectrl   (t_tr),
    .cmd_count               (cmd_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]      take;
    logic [SR_W-1:0] word;
    int              at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_count = 0;

  logic [9:0] take_vec;
  assign take_vec = {t_oa, t_noa, t_ob, t_ba, t_nba, t_bb, t_nbb, t_bc, t_nbc, t_tr};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    check("onehot0", 64'($onehot0(take_vec)), 64'd1);
    if (take_vec != 10'd0) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 64'(take_vec), 64'd0);
      end else begin
        e = q.pop_front();
        check("take", 64'(take_vec), 64'(e.take));
        check("jdo", 64'(jdo), 64'(e.word));
        check("latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  function automatic logic [SR_W-1:0] mk(input logic [2:0] b37_35, input logic b34, input logic b15);
    logic [SR_W-1:0] v;
    v = BASE;
    v[37:35] = b37_35;
    v[34] = b34;
    v[15] = b15;
    return v;
  endfunction

  task automatic uir(input logic [1:0] ir);
    @(negedge clk);
    ir_in = ir;
    vs_uir = 1'b1;
    repeat (3) @(negedge clk);
    vs_uir = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic udr(input logic [SR_W-1:0] v, input logic [9:0] exp_take);
    @(negedge clk);
    sr = v;
    vs_udr = 1'b1;
    if (exp_take != T_NONE) q.push_back('{exp_take, v, cyc + 4});
    exp_count = (exp_count >= 255) ? 255 : exp_count + 1;
    repeat (3) @(negedge clk);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // 1: strobes while reset is held are ignored
    sr = '1;
    repeat (2) @(negedge clk);
    check("rst_jdo", 64'(jdo), 64'd0);
    check("rst_count", 64'(cmd_count), 64'd0);
    vs_udr = 1'b1; repeat (3) @(negedge clk);
    vs_udr = 1'b0; repeat (2) @(negedge clk);
    vs_udr = 1'b1; repeat (3) @(negedge clk);
    vs_udr = 1'b0; repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rel_jdo", 64'(jdo), 64'd0);
    check("rel_count", 64'(cmd_count), 64'd0);

    // 2: OCI memory commands
    uir(2'b00);
    udr(mk(3'b000, 1'b1, 1'b0), T_OA);
    check("jdo_hold", 64'(jdo), 64'(mk(3'b000, 1'b1, 1'b0)));
    check("count_1", 64'(cmd_count), 64'd1);
    udr(mk(3'b000, 1'b0, 1'b1), T_NOA);
    udr(mk(3'b001, 1'b0, 1'b0), T_OB);

    // 3: break commands, sr[37:35]
    uir(2'b10);
    udr(mk(3'b110, 1'b0, 1'b0), T_BB);
    udr(mk(3'b011, 1'b1, 1'b0), T_NBC);
    udr(mk(3'b100, 1'b0, 1'b0), T_BA);
    udr(mk(3'b001, 1'b0, 1'b0), T_NBA);
    udr(mk(3'b010, 1'b0, 1'b0), T_NBB);
    udr(mk(3'b111, 1'b0, 1'b0), T_BC);

    // 4: trace control, and a silent ir=11 command that still counts
    uir(2'b11);
    udr(mk(3'b000, 1'b0, 1'b1), T_TR);
    udr(mk(3'b111, 1'b1, 1'b0), T_NONE);
    check("count_silent", 64'(cmd_count), 64'd11);
    uir(2'b01);
    udr(mk(3'b001, 1'b1, 1'b1), T_NONE);
    check("count_rsvd", 64'(cmd_count), 64'd12);

    // 6: uir and udr together, decode sees the new ir
    @(negedge clk);
    ir_in = 2'b00;
    sr = mk(3'b001, 1'b0, 1'b0);
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    q.push_back('{T_OB, mk(3'b001, 1'b0, 1'b0), cyc + 4});
    exp_count++;
    repeat (3) @(negedge clk);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
    check("count_simul", 64'(cmd_count), 64'd13);

    // 5a: reset mid-flight discards the pending command
    @(negedge clk);
    sr = mk(3'b000, 1'b1, 1'b0);
    vs_udr = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    vs_udr = 1'b0;
    exp_count = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_count", 64'(cmd_count), 64'd0);
    check("midrst_jdo", 64'(jdo), 64'd0);

    // 5b: counter saturation
    uir(2'b01);
    for (int i = 0; i < 260; i++) udr(BASE ^ 38'(i), T_NONE);
    check("count_sat", 64'(cmd_count), 64'd255);
    check("count_model", 64'(cmd_count), 64'(exp_count));

    repeat (10) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
